// File: rtl/rv32i_cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_cpu_pkg
//  Description : Shared RV32I opcode/funct3 codes, ALU operation encodings
//                and the pure-combinational ALU and branch-compare helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_cpu_pkg;

    localparam int XLEN = 32;

    // Major opcodes (instruction[6:0])
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // ALU funct3 codes
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3 codes
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    // alt carries instruction[30] where it selects SUB or SRA/SRAI
    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] alu_eval(input alu_op_e op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: return {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   return a | b;
            default:  return a & b;
        endcase
    endfunction

    // Reserved branch funct3 values (010/011) never branch
    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
        case (f3)
            F3_BEQ:  return a == b;
            F3_BNE:  return a != b;
            F3_BLT:  return $signed(a) <  $signed(b);
            F3_BGE:  return $signed(a) >= $signed(b);
            F3_BLTU: return a <  b;
            F3_BGEU: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_cpu_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_cpu_reg_file
//  Description : 32 x 32-bit integer register file, two async read ports,
//                one synchronous write port, async clear; x0 reads as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_cpu_reg_file
    import rv32i_cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic [4:0]      i_rs1_addr,
    input  logic [4:0]      i_rs2_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    input  logic            i_we,
    input  logic [4:0]      i_rd_addr,
    input  logic [XLEN-1:0] i_rd_data
);

    logic [XLEN-1:0] registers [0:31];

    // Async read; x0 is forced to zero independent of array contents
    always_comb begin
        o_rs1_data = (i_rs1_addr == 5'd0) ? '0 : registers[i_rs1_addr];
        o_rs2_data = (i_rs2_addr == 5'd0) ? '0 : registers[i_rs2_addr];
    end

    // Write port with async clear; writes to x0 are dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                registers[i] <= '0;
            end
        end else if (i_we && (i_rd_addr != 5'd0)) begin
            registers[i_rd_addr] <= i_rd_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rv32i_cpu.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_cpu
//  Description : Single-cycle RV32I core; fetch, decode, execute and retire
//                one instruction per clock against async ROM/RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_cpu
    import rv32i_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instruction,
    input  logic [31:0] mem_rd_data,
    output logic        mem_wr_sig,
    output logic [31:0] mem_wr_data,
    output logic [31:0] mem_addr,
    output logic [31:0] rom_addr
);

    logic [31:0] r_pc;
    logic [31:0] w_next_pc;
    logic [31:0] w_pc_plus4;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_rs1_data, w_rs2_data;
    logic [31:0] w_alu_b, w_alu_result;
    alu_op_e     w_alu_op;
    logic        w_alu_alt;
    logic        w_rd_we;
    logic [31:0] w_rd_data;
    logic        w_mem_wr;

    assign w_opcode   = instruction[6:0];
    assign w_funct3   = instruction[14:12];
    assign w_pc_plus4 = r_pc + 32'd4;

    assign w_imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign w_imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign w_imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};
    assign w_imm_u = {instruction[31:12], 12'd0};
    assign w_imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                      instruction[20], instruction[30:21], 1'b0};

    rv32i_cpu_reg_file reg_file_inst (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_rs1_addr (instruction[19:15]),
        .i_rs2_addr (instruction[24:20]),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data),
        .i_we       (w_rd_we),
        .i_rd_addr  (instruction[11:7]),
        .i_rd_data  (w_rd_data)
    );

    // ALU operand/op select; bit 30 only means SRAI for the immediate form
    always_comb begin
        w_alu_alt    = (w_opcode == OP_REG) ? instruction[30]
                                            : ((w_funct3 == F3_SR) && instruction[30]);
        w_alu_op     = alu_decode(w_funct3, w_alu_alt);
        w_alu_b      = (w_opcode == OP_REG) ? w_rs2_data : w_imm_i;
        w_alu_result = alu_eval(w_alu_op, w_rs1_data, w_alu_b);
    end

    // Main decode: writeback select, store strobe and next-PC
    always_comb begin
        w_rd_we   = 1'b0;
        w_rd_data = w_alu_result;
        w_mem_wr  = 1'b0;
        w_next_pc = w_pc_plus4;
        case (w_opcode)
            OP_LUI: begin
                w_rd_we   = 1'b1;
                w_rd_data = w_imm_u;
            end
            OP_AUIPC: begin
                w_rd_we   = 1'b1;
                w_rd_data = r_pc + w_imm_u;
            end
            OP_JAL: begin
                w_rd_we   = 1'b1;
                w_rd_data = w_pc_plus4;
                w_next_pc = r_pc + w_imm_j;
            end
            OP_JALR: begin
                w_rd_we   = 1'b1;
                w_rd_data = w_pc_plus4;
                w_next_pc = (w_rs1_data + w_imm_i) & ~32'd1;
            end
            OP_BRANCH: begin
                if (branch_taken(w_funct3, w_rs1_data, w_rs2_data)) begin
                    w_next_pc = r_pc + w_imm_b;
                end
            end
            OP_LOAD: begin
                w_rd_we   = 1'b1;
                w_rd_data = mem_rd_data;
            end
            OP_STORE: begin
                w_mem_wr = 1'b1;
            end
            OP_IMM, OP_REG: begin
                w_rd_we = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Program counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    assign rom_addr    = r_pc;
    assign mem_addr    = w_rs1_data + ((w_opcode == OP_STORE) ? w_imm_s : w_imm_i);
    assign mem_wr_data = w_rs2_data;
    assign mem_wr_sig  = w_mem_wr & reset_n;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_cpu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32i_cpu
//  Description : Self-checking bench for rv32i_cpu with bench-side ROM/RAM,
//                an instruction-level reference model and directed programs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_cpu;

    logic        clk;
    logic        reset_n;
    logic [31:0] instruction;
    logic [31:0] mem_rd_data;
    logic        mem_wr_sig;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_addr;
    logic [31:0] rom_addr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rom [0:255];
    logic [31:0] ram [0:1023];

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_x   [0:31];
    logic [31:0] m_mem [0:1023];

    rv32i_cpu #(.RESET_PC(32'h0)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instruction (instruction),
        .mem_rd_data (mem_rd_data),
        .mem_wr_sig  (mem_wr_sig),
        .mem_wr_data (mem_wr_data),
        .mem_addr    (mem_addr),
        .rom_addr    (rom_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rom_fetch(input logic [31:0] a);
        return (a[31:10] == 22'd0) ? rom[a[9:2]] : 32'h0000_0013;
    endfunction

    assign instruction = rom_fetch(rom_addr);
    assign mem_rd_data = ram[mem_addr[11:2]];

    // Data RAM: sync write, cleared by reset
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 32'd0;
        end else if (mem_wr_sig) begin
            ram[mem_addr[11:2]] <= mem_wr_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_i(input int op, input int rd, input int f3,
                                          input int rs1, input int imm);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_s(input int f3, input int rs1, input int rs2, input int imm);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input int f3, input int rs1, input int rs2, input int imm);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_r(input int f7, input int f3, input int rd,
                                          input int rs1, input int rs2);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] enc_u(input int op, input int rd, input int imm20);
        return {imm20[19:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_j(input int rd, input int imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
    endfunction

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++)   m_x[i]   = 32'd0;
        for (int i = 0; i < 1024; i++) m_mem[i] = 32'd0;
    endtask

    task automatic model_step();
        logic [31:0] ins, a, b, imm_i, imm_s, imm_b, imm_j, val, npc, ea;
        logic        wr;
        ins   = rom_fetch(m_pc);
        a     = m_x[ins[19:15]];
        b     = m_x[ins[24:20]];
        imm_i = {{20{ins[31]}}, ins[31:20]};
        imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        npc   = m_pc + 4;
        wr    = 1'b0;
        val   = 32'd0;
        case (ins[6:0])
            7'h37: begin wr = 1; val = {ins[31:12], 12'd0}; end
            7'h17: begin wr = 1; val = m_pc + {ins[31:12], 12'd0}; end
            7'h6F: begin wr = 1; val = m_pc + 4; npc = m_pc + imm_j; end
            7'h67: begin wr = 1; val = m_pc + 4; npc = (a + imm_i) & 32'hFFFF_FFFE; end
            7'h63: begin
                logic t;
                case (ins[14:12])
                    3'd0: t = (a == b);
                    3'd1: t = (a != b);
                    3'd4: t = ($signed(a) <  $signed(b));
                    3'd5: t = ($signed(a) >= $signed(b));
                    3'd6: t = (a <  b);
                    3'd7: t = (a >= b);
                    default: t = 1'b0;
                endcase
                if (t) npc = m_pc + imm_b;
            end
            7'h03: begin wr = 1; ea = a + imm_i; val = m_mem[ea[11:2]]; end
            7'h23: begin ea = a + imm_s; m_mem[ea[11:2]] = b; end
            7'h13, 7'h33: begin
                logic [31:0] op2;
                op2 = (ins[6:0] == 7'h13) ? imm_i : b;
                wr  = 1;
                case (ins[14:12])
                    3'd0: val = (ins[6:0] == 7'h33 && ins[30]) ? a - op2 : a + op2;
                    3'd1: val = a << op2[4:0];
                    3'd2: val = ($signed(a) < $signed(op2)) ? 32'd1 : 32'd0;
                    3'd3: val = (a < op2) ? 32'd1 : 32'd0;
                    3'd4: val = a ^ op2;
                    3'd5: val = ins[30] ? $unsigned($signed(a) >>> op2[4:0]) : a >> op2[4:0];
                    3'd6: val = a | op2;
                    default: val = a & op2;
                endcase
            end
            default: ;
        endcase
        if (wr && ins[11:7] != 5'd0) m_x[ins[11:7]] = val;
        m_pc = npc;
    endtask

    // Per-cycle comparison of DUT against model, then advance the model
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                model_reset();
                chk("wr_sig_in_reset", {31'd0, mem_wr_sig}, 32'd0);
            end else begin
                logic [31:0] ins;
                ins = rom_fetch(m_pc);
                chk("rom_addr", rom_addr, m_pc);
                chk("mem_wr_sig", {31'd0, mem_wr_sig}, {31'd0, ins[6:0] == 7'h23});
                if (ins[6:0] == 7'h23) begin
                    chk("st_addr", mem_addr, m_x[ins[19:15]] + {{20{ins[31]}}, ins[31:25], ins[11:7]});
                    chk("st_data", mem_wr_data, m_x[ins[24:20]]);
                end
                for (int r = 0; r < 32; r++)
                    chk($sformatf("x%0d", r), dut.reg_file_inst.registers[r], m_x[r]);
                model_step();
            end
        end
    end

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 32'h0000_0013;
    endtask

    task automatic load_prog1();
        clear_rom();
        rom[0]  = enc_i(7'h13, 29, 0, 0, 55);
        rom[1]  = enc_i(7'h13, 1, 0, 29, -56);
        rom[2]  = enc_i(7'h13, 0, 0, 0, 5);
        rom[3]  = enc_s(2, 0, 29, 8);
        rom[4]  = enc_i(7'h03, 5, 2, 0, 8);
        rom[5]  = enc_b(0, 5, 29, 8);
        rom[6]  = enc_i(7'h13, 6, 0, 0, 1);
        rom[7]  = enc_b(1, 5, 29, 8);
        rom[8]  = enc_j(1, 16);
        rom[9]  = enc_i(7'h13, 7, 0, 0, -1);
        rom[10] = enc_i(7'h13, 8, 0, 0, 1);
        rom[11] = enc_b(4, 7, 8, 8);
        rom[12] = enc_i(7'h67, 0, 0, 1, 0);
        rom[13] = enc_b(6, 7, 8, 8);
        rom[14] = enc_r(7'h20, 0, 9, 8, 7);
        rom[15] = enc_r(7'h20, 5, 10, 7, 8);
        rom[16] = enc_r(7'h00, 5, 11, 7, 8);
        rom[17] = enc_r(7'h00, 3, 12, 8, 7);
        rom[18] = enc_r(7'h00, 2, 13, 8, 7);
        rom[19] = enc_u(7'h37, 14, 'h12345);
        rom[20] = enc_u(7'h17, 15, 1);
        rom[21] = enc_i(7'h13, 16, 4, 7, 'h0F0);
        rom[22] = 32'h0000_0073;
        rom[23] = enc_j(0, 0);
    endtask

    task automatic load_prog2();
        clear_rom();
        rom[0]  = enc_i(7'h13, 2, 0, 0, 1024);
        rom[1]  = enc_i(7'h13, 10, 0, 0, 10);
        rom[2]  = enc_j(1, 12);
        rom[3]  = enc_r(0, 0, 29, 11, 0);
        rom[4]  = enc_j(0, 0);
        rom[5]  = enc_b(1, 10, 0, 12);
        rom[6]  = enc_i(7'h13, 11, 0, 0, 0);
        rom[7]  = enc_i(7'h67, 0, 0, 1, 0);
        rom[8]  = enc_i(7'h13, 2, 0, 2, -8);
        rom[9]  = enc_s(2, 2, 1, 4);
        rom[10] = enc_s(2, 2, 10, 0);
        rom[11] = enc_i(7'h13, 10, 0, 10, -1);
        rom[12] = enc_j(1, -28);
        rom[13] = enc_i(7'h03, 10, 2, 2, 0);
        rom[14] = enc_i(7'h03, 1, 2, 2, 4);
        rom[15] = enc_i(7'h13, 2, 0, 2, 8);
        rom[16] = enc_r(0, 0, 11, 11, 10);
        rom[17] = enc_i(7'h67, 0, 0, 1, 0);
    endtask

    function automatic int nonzero_regs();
        int n = 0;
        for (int r = 0; r < 32; r++) if (dut.reg_file_inst.registers[r] != 32'd0) n++;
        return n;
    endfunction

    task automatic release_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic run_until_halt(input logic [31:0] halt_pc, input int budget, input string name);
        int n = 0;
        while (!(rom_addr == halt_pc && dut.reg_file_inst.registers[29] == 32'd55) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_in_budget"}, {31'd0, n < budget}, 32'd1);
    endtask

    logic [31:0] exp_pc [0:23];

    initial begin
        reset_n = 1'b0;
        load_prog1();
        exp_pc = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h1C, 32'h20,
                   32'h30, 32'h24, 32'h28, 32'h2C, 32'h34, 32'h38, 32'h3C, 32'h40,
                   32'h44, 32'h48, 32'h4C, 32'h50, 32'h54, 32'h58, 32'h5C, 32'h5C};
        repeat (3) @(posedge clk);
        #2;
        chk("reset_rom_addr", rom_addr, 32'd0);
        chk("reset_regs_nonzero", nonzero_regs(), 32'd0);
        chk("reset_wr_sig", {31'd0, mem_wr_sig}, 32'd0);
        release_reset();

        // Directed program: literal PC trace and selected register values
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            chk($sformatf("pc_seq[%0d]", i), rom_addr, exp_pc[i]);
            if (i == 2) begin
                chk("addi_x29", dut.reg_file_inst.registers[29], 32'd55);
                chk("addi_x1_neg", dut.reg_file_inst.registers[1], 32'hFFFF_FFFF);
            end
            if (i == 3) begin
                chk("x0_stays_0", dut.reg_file_inst.registers[0], 32'd0);
                chk("sw_strobe", {31'd0, mem_wr_sig}, 32'd1);
                chk("sw_addr", mem_addr, 32'd8);
                chk("sw_data", mem_wr_data, 32'd55);
            end
            if (i == 4) chk("lw_no_strobe", {31'd0, mem_wr_sig}, 32'd0);
            if (i == 5) chk("lw_x5", dut.reg_file_inst.registers[5], 32'd55);
            if (i == 9) chk("jal_link", dut.reg_file_inst.registers[1], 32'h24);
        end
        chk("x6_skipped", dut.reg_file_inst.registers[6], 32'd0);
        chk("sub", dut.reg_file_inst.registers[9], 32'd2);
        chk("sra", dut.reg_file_inst.registers[10], 32'hFFFF_FFFF);
        chk("srl", dut.reg_file_inst.registers[11], 32'h7FFF_FFFF);
        chk("sltu", dut.reg_file_inst.registers[12], 32'd1);
        chk("slt", dut.reg_file_inst.registers[13], 32'd0);
        chk("lui", dut.reg_file_inst.registers[14], 32'h1234_5000);
        chk("auipc", dut.reg_file_inst.registers[15], 32'h0000_1050);
        chk("xori", dut.reg_file_inst.registers[16], 32'hFFFF_FF0F);
        chk("model_x1", m_x[1], 32'h24);
        chk("model_x11", m_x[11], 32'h7FFF_FFFF);
        chk("model_x16", m_x[16], 32'hFFFF_FF0F);

        // Recursive sum program, interrupted by a reset pulse mid-run
        @(posedge clk);
        #3 reset_n = 1'b0;
        load_prog2();
        release_reset();
        repeat (60) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("midreset_pc", rom_addr, 32'd0);
        chk("midreset_regs_nonzero", nonzero_regs(), 32'd0);
        chk("midreset_wr_sig", {31'd0, mem_wr_sig}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        run_until_halt(32'h10, 3000, "sum_rerun");
        chk("sum_x29", dut.reg_file_inst.registers[29], 32'd55);
        chk("sum_model_x29", m_x[29], 32'd55);
        chk("sum_sp_restored", dut.reg_file_inst.registers[2], 32'd1024);
        repeat (3) @(negedge clk);
        chk("sum_halt_pc", rom_addr, 32'h10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
